// File: rtl/cpu_pkg.sv
// Shared definitions for the 16RISC core: bus widths, fetch FSM states and
// the address/instruction types reused by fetch and decode.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] instr_t;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // Sequential successor of a PC; wraps silently modulo 2^ADDR_W.
  function automatic addr_t pc_succ(input addr_t pc);
    return pc + addr_t'(1);
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter register: synchronous reset to 0, a parallel load for
// redirects, and an increment for sequential fetch. Load beats increment.
module pc_counter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc_en,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] r_pc;

  // PC update: reset, then redirect load, then +1 (modulo 2^ADDR_W)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= '0;
    end else if (load_en) begin
      r_pc <= load_val;
    end else if (inc_en) begin
      r_pc <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  assign pc = r_pc;

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch controller: drives the ROM address from the PC, captures
// each fetched word into a one-entry valid/ready output toward decode, and
// handles branch redirects and a sticky halt that only a branch releases.
module rom_fetch_ctrl #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  output logic              halted
);

  import cpu_pkg::*;

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] w_pc;
  logic              w_load;
  logic              w_halted;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_instr_valid;

  pc_counter #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk      (clk),
    .reset    (reset),
    .load_en  (branch_en),
    .load_val (branch_target),
    .inc_en   (w_load),
    .pc       (w_pc)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a branch always returns to FETCH (and masks a same-cycle
  // halt); halt is sticky, so dropping it does not leave HALTED
  always_comb begin
    w_state_nxt = r_state;
    if (branch_en) begin
      w_state_nxt = FETCH;
    end else if (halt && (r_state == FETCH)) begin
      w_state_nxt = HALTED;
    end
  end

  // FSM outputs: a load happens only in FETCH with the output slot free
  // (or emptying this cycle), and never alongside a branch or a new halt
  always_comb begin
    w_halted = (r_state == HALTED);
    w_load   = (r_state == FETCH) && (!r_instr_valid || instr_ready)
               && !branch_en && !halt;
  end

  // One-entry instruction register: branch discards the held word, a load
  // replaces it, otherwise it is held until decode takes it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else if (branch_en) begin
      r_instr_valid <= 1'b0;
    end else if (w_load) begin
      r_instr       <= rom_data;
      r_instr_pc    <= w_pc;
      r_instr_valid <= 1'b1;
    end else if (r_instr_valid && instr_ready) begin
      r_instr_valid <= 1'b0;
    end
  end

  assign rom_addr    = w_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign halted      = w_halted;

endmodule
